// File: rtl/pad_gpio_pkg.sv
// Shared constants for the pad GPIO controller.
// Register indices, reset value and the pin-count ceiling.
package pad_gpio_pkg;

  localparam int MAX_NPINS = 32;

  localparam logic [2:0] ADDR_IN_VAL  = 3'd0;
  localparam logic [2:0] ADDR_OUT_EN  = 3'd1;
  localparam logic [2:0] ADDR_OUT_VAL = 3'd2;
  localparam logic [2:0] ADDR_IOF_EN  = 3'd3;
  localparam logic [2:0] ADDR_RISE_IE = 3'd4;
  localparam logic [2:0] ADDR_FALL_IE = 3'd5;
  localparam logic [2:0] ADDR_RISE_IP = 3'd6;
  localparam logic [2:0] ADDR_FALL_IP = 3'd7;

  localparam logic [MAX_NPINS-1:0] RST_VAL = '0;

endpackage

// File: rtl/pad_gpio_if.sv
// Register bus between the SoC peripheral bus and the GPIO block.
// Ports: reg_wr, reg_rd, reg_addr, reg_wdata in; reg_rdata back.
interface pad_gpio_if #(
  parameter int NPINS = 8
) ();

  logic             reg_wr;
  logic             reg_rd;
  logic [2:0]       reg_addr;
  logic [NPINS-1:0] reg_wdata;
  logic [NPINS-1:0] reg_rdata;

  modport master (
    output reg_wr,
    output reg_rd,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wr,
    input  reg_rd,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/pad_sync_edge.sv
// Input synchroniser chain plus one history flop for edge detect.
// Ports: clk, rst, i_d (async) -> o_sync, o_rise, o_fall.
module pad_sync_edge #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_chain [STAGES];
  logic [W-1:0] r_hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++)
        r_chain[s] <= '0;
      r_hist <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int s = 1; s < STAGES; s++)
        r_chain[s] <= r_chain[s-1];
      r_hist <= r_chain[STAGES-1];
    end
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_hist;
  assign o_fall = ~o_sync & r_hist;

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Register-programmable GPIO pad controller with IOF mux and edge irqs.
// Ports: clk, rst, bus (slave), pad_i/pad_o/pad_oe, iof_o/iof_oe/iof_i, irq.
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int NPINS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  pad_gpio_if.slave        bus,
  input  logic [NPINS-1:0] pad_i,
  output logic [NPINS-1:0] pad_o,
  output logic [NPINS-1:0] pad_oe,
  input  logic [NPINS-1:0] iof_o,
  input  logic [NPINS-1:0] iof_oe,
  output logic [NPINS-1:0] iof_i,
  output logic [NPINS-1:0] irq
);

  localparam logic [NPINS-1:0] RV = RST_VAL[NPINS-1:0];

  logic [NPINS-1:0] r_out_en;
  logic [NPINS-1:0] r_out_val;
  logic [NPINS-1:0] r_iof_en;
  logic [NPINS-1:0] r_rise_ie;
  logic [NPINS-1:0] r_fall_ie;
  logic [NPINS-1:0] r_rise_ip;
  logic [NPINS-1:0] r_fall_ip;
  logic [NPINS-1:0] r_rdata;
  logic [NPINS-1:0] r_irq;

  logic [NPINS-1:0] w_sync;
  logic [NPINS-1:0] w_rise;
  logic [NPINS-1:0] w_fall;
  logic [NPINS-1:0] w_rd_mux;
  logic [NPINS-1:0] w_rise_clr;
  logic [NPINS-1:0] w_fall_clr;

  pad_sync_edge #(
    .W      (NPINS),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (pad_i),
    .o_sync (w_sync),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_rd_mux = '0;
    unique case (bus.reg_addr)
      ADDR_IN_VAL:  w_rd_mux = w_sync;
      ADDR_OUT_EN:  w_rd_mux = r_out_en;
      ADDR_OUT_VAL: w_rd_mux = r_out_val;
      ADDR_IOF_EN:  w_rd_mux = r_iof_en;
      ADDR_RISE_IE: w_rd_mux = r_rise_ie;
      ADDR_FALL_IE: w_rd_mux = r_fall_ie;
      ADDR_RISE_IP: w_rd_mux = r_rise_ip;
      ADDR_FALL_IP: w_rd_mux = r_fall_ip;
    endcase
  end

  // W1C masks; a same-edge set is OR'd in after the clear so set wins
  assign w_rise_clr = (bus.reg_wr && bus.reg_addr == ADDR_RISE_IP)
                    ? bus.reg_wdata : '0;
  assign w_fall_clr = (bus.reg_wr && bus.reg_addr == ADDR_FALL_IP)
                    ? bus.reg_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_en  <= RV;
      r_out_val <= RV;
      r_iof_en  <= RV;
      r_rise_ie <= RV;
      r_fall_ie <= RV;
      r_rise_ip <= RV;
      r_fall_ip <= RV;
      r_rdata   <= RV;
      r_irq     <= RV;
    end else begin
      if (bus.reg_rd)
        r_rdata <= w_rd_mux;
      if (bus.reg_wr && bus.reg_addr == ADDR_OUT_EN)
        r_out_en <= bus.reg_wdata;
      if (bus.reg_wr && bus.reg_addr == ADDR_OUT_VAL)
        r_out_val <= bus.reg_wdata;
      if (bus.reg_wr && bus.reg_addr == ADDR_IOF_EN)
        r_iof_en <= bus.reg_wdata;
      if (bus.reg_wr && bus.reg_addr == ADDR_RISE_IE)
        r_rise_ie <= bus.reg_wdata;
      if (bus.reg_wr && bus.reg_addr == ADDR_FALL_IE)
        r_fall_ie <= bus.reg_wdata;
      r_rise_ip <= (r_rise_ip & ~w_rise_clr) | w_rise;
      r_fall_ip <= (r_fall_ip & ~w_fall_clr) | w_fall;
      r_irq     <= (r_rise_ip & r_rise_ie)
                 | (r_fall_ip & r_fall_ie);
    end
  end

  assign bus.reg_rdata = r_rdata;
  assign irq           = r_irq;
  assign iof_i         = w_sync;
  assign pad_o  = (iof_o  & r_iof_en) | (r_out_val & ~r_iof_en);
  assign pad_oe = (iof_oe & r_iof_en) | (r_out_en  & ~r_iof_en);

endmodule

// File: doc/pad_gpio_ctrl.md
Name: pad_gpio_ctrl

Overview:
- Register-programmable controller for a bank of NPINS bidirectional FPGA I/O pads.
- Per pin it drives the pad data-out and output-enable, and synchronises the pad data-in back into the clock domain.
- Per pin it can hand the pad to a peripheral I/O function (IOF), and it raises rise/fall edge interrupts.
- Sits between the SoC peripheral bus and the pad instances in the FPGA top level.

Parameters:
- NPINS, 8, number of pads controlled (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..3).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- reg_wr  input  1  register write strobe.
- reg_rd  input  1  register read strobe.
- reg_addr  input  3  word register index.
- reg_wdata  input  NPINS  write data.
- reg_rdata  output  NPINS  read data, registered.
- pad_i  input  NPINS  pad data-in, asynchronous.
- pad_o  output  NPINS  pad data-out.
- pad_oe  output  NPINS  pad output enable; 1 = drive, 0 = high-Z.
- iof_o  input  NPINS  peripheral data-out.
- iof_oe  input  NPINS  peripheral output enable.
- iof_i  output  NPINS  synchronised pad input to the peripheral.
- irq  output  NPINS  per-pin level interrupt.

Behaviour:
- One clock domain; reset is synchronous and active-high, taken at the rising edge of clk.
- Reset clears every register to 0, so reg_rdata=0, pad_oe=0 (all pads tristate), pad_o=0 and irq=0. The synchroniser and edge-history flops are also 0.
- Register map (reg_addr):
  - 0 IN_VAL: RO, synchronised input.
  - 1 OUT_EN: RW.
  - 2 OUT_VAL: RW.
  - 3 IOF_EN: RW.
  - 4 RISE_IE: RW.
  - 5 FALL_IE: RW.
  - 6 RISE_IP: write-1-to-clear.
  - 7 FALL_IP: write-1-to-clear.
- Writes to IN_VAL are ignored.
- Write: the register updates at the edge where reg_wr=1. The new value is visible on pad_o/pad_oe the cycle after.
- Read: reg_rdata is loaded at the edge where reg_rd=1, giving 1-cycle latency. reg_rdata holds its value while reg_rd=0.
- Read and write together: the write takes effect and reg_rdata returns the pre-write value.
- Pad mux per pin i (combinational from registers and iof inputs, no added latency):
  - IOF_EN[i]=1: pad_o[i]=iof_o[i], pad_oe[i]=iof_oe[i].
  - IOF_EN[i]=0: pad_o[i]=OUT_VAL[i], pad_oe[i]=OUT_EN[i].
- iof_i is always the synchronised input, regardless of IOF_EN.
- Synchroniser: a SYNC_STAGES flop chain. For SYNC_STAGES=2, a pad_i change set up before edge k appears in IN_VAL/iof_i after edge k+1.
- Edge detect:
  - One history flop holds the previous synchronised value.
  - rise = sync & ~hist; fall = ~sync & hist.
  - RISE_IP[i] / FALL_IP[i] set at edge k+2 (SYNC_STAGES=2).
- Pending bits set regardless of the enable state. IE only gates irq.
- Set and W1C on the same edge for the same bit: set wins, bit stays 1.
- W1C of a 0 bit: no effect.
- irq[i] = (RISE_IP[i]&RISE_IE[i]) | (FALL_IP[i]&FALL_IE[i]), registered. It asserts 1 cycle after the pending/enable change.
- Loopback: a pin driven as output still feeds the synchroniser, so edges on driven pins set IP bits.
- Reset mid-operation: all state returns to 0 on that edge and pads release immediately. Any in-flight read returns 0.

Decomposition:
- Shared package pad_gpio_pkg holds:
  - register index constants (ADDR_IN_VAL..ADDR_FALL_IP);
  - the reset value constant;
  - the maximum NPINS.
- One sub-module, pad_sync_edge:
  - SYNC_STAGES synchroniser plus history flop;
  - outputs sync, rise and fall;
  - instantiated NPINS-wide, one vector instance.
- Pad instances stay outside this block, in the FPGA top.

Test Plan:
- Reset defaults: assert rst for 2 cycles, then read all 8 registers. All read 0; pad_oe=0, irq=0.
- GPIO drive: write OUT_EN=0x0F, then OUT_VAL=0xA5. The next cycle pad_oe=0x0F and pad_o=0xA5. Read OUT_VAL returns 0xA5 one cycle after reg_rd.
- IOF takeover: write IOF_EN=0x01 with iof_oe=0x01, iof_o=0x00. pad_o[0]=0 and pad_oe[0]=1 the next cycle. Clearing IOF_EN restores OUT_VAL[0]=1.
- Edge interrupt: write RISE_IE=0x04 and drive pad_i[2] 0->1 before edge k.
  - IN_VAL[2]=1 after edge k+1.
  - RISE_IP=0x04 after edge k+2.
  - irq[2]=1 after edge k+3.
  - W1C 0x04 clears irq one cycle later.
- Set/clear collision: time a W1C to RISE_IP[2] on the same edge as a new rising edge on pin 2. RISE_IP[2] remains 1.
- Mid-operation reset: with OUT_EN=0xFF and pending IPs set, pulse rst for 1 cycle. The next cycle pad_oe=0x00, irq=0x00, and all registers read 0.
